sc_lut_arb: RTL and testbench
=============================

# sc_lut_arb

Round-robin arbiter that shares one sine/cosine lookup table (`sc_lut`) between N independent requesters, such as per-voice phase accumulators and output mixers. It accepts at most one address per cycle and forwards it to the LUT. It tracks the fixed two-cycle LUT latency with a tagged valid pipeline and routes each result back to the requester that issued it. Sits between the voice/oscillator logic and the single block-RAM LUT instance.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `asz`, default 10: LUT address width.
- `dsz`, default 14: LUT data width.
- `LAT`, default 2: LUT read latency in cycles (address register + BRAM output register).

Ports, one per line: name, direction, width, meaning.
- `clk`, in, 1: system clock. Single clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `req_valid`, in, NREQ: per-requester request strobe. Held until granted.
- `req_addr`, in, NREQ*asz: packed addresses. Requester i uses bits [i*asz +: asz].
- `req_ready`, out, NREQ: one-hot grant. Combinational from `req_valid` and the priority pointer.
- `lut_a`, out, asz: address to the LUT. Combinational mux of the granted `req_addr`.
- `lut_d`, in, dsz: signed LUT output.
- `rsp_valid`, out, NREQ: one-hot response strobe, registered.
- `rsp_data`, out, dsz: signed result. Meaningful only while any `rsp_valid` bit is high.
- `busy`, out, 1: high while any lookup is in flight.

## Operation
- Grant: exactly one `req_ready` bit is high whenever `req_valid` is non-zero; all bits are zero otherwise. A transfer occurs when `req_valid[i] & req_ready[i]`.
- Priority: a round-robin pointer `ptr` (width clog2(NREQ), reset 0).
  - The search starts at `ptr` and wraps modulo NREQ.
  - After a grant to requester g, `ptr` becomes (g+1) mod NREQ.
  - With no grant, `ptr` is unchanged.
- `lut_a`:
  - Equals the granted address.
  - Equals 0 when nothing is granted. The LUT still reads, but the result is tagged invalid.
- Tag pipeline: LAT stages of {valid, id}. Stage 0 loads {transfer, g}; each later stage shifts every cycle. There is no stall: the LUT is always enabled, and requesters must accept responses.
- `rsp_valid`: one-hot decode of the last stage's id, gated by its valid bit.
- `rsp_data`: `lut_d` passed through unmodified. It is aligned with the last stage by construction.
- `busy`: OR of all stage valid bits.
- Simultaneous events: requesters present in the same cycle are served in consecutive cycles in round-robin order. A requester may re-request in the same cycle its response returns.
- Reset mid-operation: all in-flight tags are cleared, so their LUT results are dropped and no `rsp_valid` is asserted for them. `ptr` returns to 0.

## Timing
- Reset values:
  - `rsp_valid` = 0, `busy` = 0, `ptr` = 0, all stage valid bits = 0.
  - `req_ready` and `lut_a` are combinational and follow the inputs. Grants issued while `reset` is high are discarded.
- Latency: a transfer in cycle t gives `rsp_valid[g]` = 1 and `rsp_data` = LUT[addr] during cycle t+LAT (t+2 by default).
- Throughput: one lookup per cycle in aggregate. Any single requester gets at least one grant every NREQ cycles under full load.
- Response strobes last exactly one cycle. A new response can arrive every cycle.

## Structure
- Shared package/header `sc_lut_pkg`: defaults for `asz`, `dsz`, and `LAT`; a clog2 function; the tag-stage field layout.
- One sub-module, `rr_arbiter`: parameterised NREQ round-robin grant plus pointer update. It is reusable by the other shared-resource blocks.
- The top level holds the address mux, tag pipeline, and response decode. It instantiates `sc_lut` directly only in the integration wrapper, not inside this block.

## Test plan
1. Single request: `req_valid`=0001, `req_addr[0]`=10'h100 for one cycle. `lut_a`=10'h100 that cycle; `rsp_valid`=0001 two cycles later with `rsp_data`=LUT[256] (model value); `busy` high for 2 cycles.
2. All four requesting continuously, `ptr`=0. Grants follow 0,1,2,3,0,… one per cycle; each `rsp_valid` bit pulses every 4 cycles with the correct per-id data.
3. Fairness after skew: requesters 2 and 3 valid while `ptr`=3. Grant 3 then 2; `ptr` ends at 3.
4. Back-to-back from one requester: `req_valid`=0100 held 5 cycles with addresses 0..4. Five consecutive `rsp_valid`=0100 pulses with data LUT[0..4] in order.
5. Reset mid-flight: two lookups issued, `reset` asserted for one cycle on the next edge. No `rsp_valid` appears, `busy`=0, and the next grant goes to requester 0 first.
6. Idle: `req_valid`=0 for 10 cycles. `req_ready`=0, `lut_a`=0, `rsp_valid`=0, `ptr` unchanged.

Source files
------------

// File: rtl/sc_lut_pkg.sv
// Shared definitions for blocks that share the sine/cosine LUT:
// width defaults, a clog2 helper, and the layout of one in-flight tag stage.
package sc_lut_pkg;

    localparam int ASZ_DEF = 10;
    localparam int DSZ_DEF = 14;
    localparam int LAT_DEF = 2;
    localparam int ID_W    = 3;   // wide enough for up to 8 requesters

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant searching upward from ptr,
// pointer moves to one past the winner after every grant.
module rr_arbiter
    import sc_lut_pkg::*;
#(
    parameter int  NREQ = 4,
    localparam int PW   = clog2(NREQ)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   gnt_id_o
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;
    logic [PW-1:0] idx_w;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = 0;
        idx_w    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx   = (int'(ptr_q) + k) % NREQ;
            idx_w = PW'(idx);
            if (!found && req_i[idx_w]) begin
                found        = 1'b1;
                gnt_o[idx_w] = 1'b1;
                gnt_id_o     = idx_w;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            if (int'(gnt_id_o) == NREQ - 1) ptr_d = '0;
            else                            ptr_d = gnt_id_o + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sc_lut_arb.sv
// Shares one fixed-latency sin/cos LUT among NREQ requesters: round-robin
// address mux in front, tagged valid pipeline routing results back behind.
module sc_lut_arb
    import sc_lut_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int asz  = ASZ_DEF,
    parameter int dsz  = DSZ_DEF,
    parameter int LAT  = LAT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*asz-1:0]    req_addr,
    output logic [NREQ-1:0]        req_ready,
    output logic [asz-1:0]         lut_a,
    input  logic signed [dsz-1:0]  lut_d,
    output logic [NREQ-1:0]        rsp_valid,
    output logic signed [dsz-1:0]  rsp_data,
    output logic                   busy
);

    localparam int PW = clog2(NREQ);

    logic [PW-1:0]        gnt_id;
    logic                 xfer;
    tag_t [LAT-1:0]       tag_q, tag_d;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk_i    (clk),
        .reset_i  (reset),
        .req_i    (req_valid),
        .gnt_o    (req_ready),
        .gnt_id_o (gnt_id)
    );

    assign xfer = |req_valid;

    // Grant is one-hot, so an OR of gated addresses is the mux; zero when idle.
    always_comb begin
        lut_a = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) lut_a = lut_a | req_addr[i*asz +: asz];
        end
    end

    always_comb begin
        tag_d        = tag_q;
        tag_d[0].vld = xfer;
        tag_d[0].id  = ID_W'(gnt_id);
        for (int s = 1; s < LAT; s++) tag_d[s] = tag_q[s-1];
    end

    // Clearing tags on reset drops any LUT results still in flight.
    always_ff @(posedge clk) begin
        if (reset) tag_q <= '0;
        else       tag_q <= tag_d;
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = tag_q[LAT-1].vld && (tag_q[LAT-1].id == ID_W'(i));
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < LAT; s++) busy = busy | tag_q[s].vld;
    end

    assign rsp_data = lut_d;

endmodule

// File: tb/tb_sc_lut_arb.sv
// Directed bench for sc_lut_arb with a two-cycle LUT model behind it.
module tb_sc_lut_arb;

    localparam int NREQ = 4;
    localparam int ASZ  = 10;
    localparam int DSZ  = 14;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*ASZ-1:0]    req_addr = '0;
    logic [NREQ-1:0]        req_ready;
    logic [ASZ-1:0]         lut_a;
    logic signed [DSZ-1:0]  lut_d;
    logic [NREQ-1:0]        rsp_valid;
    logic signed [DSZ-1:0]  rsp_data;
    logic                   busy;

    int n_chk  = 0;
    int n_fail = 0;
    logic [ASZ-1:0] exp_addr [NREQ];
    logic [ASZ-1:0] a_q;

    sc_lut_arb #(.NREQ(NREQ), .asz(ASZ), .dsz(DSZ), .LAT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .lut_a     (lut_a),
        .lut_d     (lut_d),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic signed [DSZ-1:0] lutf(input logic [ASZ-1:0] a);
        return $signed({a, 4'h0} ^ 14'h15A5);
    endfunction

    // Address register then output register: two cycles of latency.
    always @(posedge clk) begin
        a_q   <= lut_a;
        lut_d <= lutf(a_q);
    end

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic seta(input int i, input logic [ASZ-1:0] v);
        req_addr[i*ASZ +: ASZ] = v;
        exp_addr[i] = v;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) exp_addr[i] = '0;
        reset = 1'b1;
        cyc; cyc;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        reset = 1'b0;

        // single request from requester 0
        seta(0, 10'h100);
        req_valid = 4'b0001; #1;
        chk("t1_ready", 64'(req_ready), 64'h1);
        chk("t1_lut_a", 64'(lut_a), 64'h100);
        cyc; req_valid = '0; #1;
        chk("t1_busy1", 64'(busy), 64'h1);
        chk("t1_rsp_early", 64'(rsp_valid), 64'h0);
        cyc; #1;
        chk("t1_rsp", 64'(rsp_valid), 64'h1);
        chk("t1_data", 64'(rsp_data), 64'(lutf(10'h100)));
        chk("t1_busy2", 64'(busy), 64'h1);
        cyc; #1;
        chk("t1_rsp_done", 64'(rsp_valid), 64'h0);
        chk("t1_busy_done", 64'(busy), 64'h0);

        // pointer is 1 now; a grant to 3 brings it back to 0
        req_valid = 4'b1000; #1;
        chk("align_ready", 64'(req_ready), 64'h8);
        cyc; req_valid = '0;
        cyc; cyc;

        // all four requesting continuously
        for (int i = 0; i < NREQ; i++) seta(i, ASZ'(10'h040 + i * 3));
        for (int k = 0; k < 12; k++) begin
            req_valid = (k < 10) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 10) begin
                chk("t2_ready", 64'(req_ready), 64'(1) << (k % 4));
                chk("t2_lut_a", 64'(lut_a), 64'(exp_addr[k % 4]));
            end
            if (k >= 2) begin
                chk("t2_rsp", 64'(rsp_valid), 64'(1) << ((k - 2) % 4));
                chk("t2_data", 64'(rsp_data), 64'(lutf(exp_addr[(k - 2) % 4])));
            end
            cyc;
        end
        // ptr = 2 after last grant to requester 1

        // fairness: grant 2 moves ptr to 3, then 3 before 2
        req_valid = 4'b0100; #1;
        chk("t3_g0", 64'(req_ready), 64'h4);
        cyc; req_valid = 4'b1100; #1;
        chk("t3_g1", 64'(req_ready), 64'h8);
        cyc; req_valid = 4'b0100; #1;
        chk("t3_g2", 64'(req_ready), 64'h4);
        chk("t3_rsp0", 64'(rsp_valid), 64'h4);
        chk("t3_data0", 64'(rsp_data), 64'(lutf(exp_addr[2])));
        cyc; req_valid = 4'b1111; #1;
        chk("t3_ptr3", 64'(req_ready), 64'h8);
        chk("t3_rsp1", 64'(rsp_valid), 64'h8);
        chk("t3_data1", 64'(rsp_data), 64'(lutf(exp_addr[3])));
        cyc; req_valid = '0; #1;
        chk("t3_rsp2", 64'(rsp_valid), 64'h4);
        cyc; #1;
        chk("t3_rsp3", 64'(rsp_valid), 64'h8);
        cyc;
        // ptr = 0

        // back-to-back from requester 2, addresses 0..4
        for (int k = 0; k < 8; k++) begin
            if (k < 5) begin
                seta(2, ASZ'(k));
                req_valid = 4'b0100;
            end else begin
                req_valid = '0;
            end
            #1;
            if (k < 5) begin
                chk("t4_ready", 64'(req_ready), 64'h4);
                chk("t4_lut_a", 64'(lut_a), 64'(k));
            end
            if (k >= 2 && k < 7) begin
                chk("t4_rsp", 64'(rsp_valid), 64'h4);
                chk("t4_data", 64'(rsp_data), 64'(lutf(ASZ'(k - 2))));
            end
            if (k == 7) begin
                chk("t4_rsp_done", 64'(rsp_valid), 64'h0);
                chk("t4_busy_done", 64'(busy), 64'h0);
            end
            cyc;
        end
        // ptr = 3

        // reset mid-flight
        seta(0, 10'h155);
        seta(1, 10'h2AA);
        req_valid = 4'b0011; #1;
        chk("t5_g0", 64'(req_ready), 64'h1);
        cyc; req_valid = 4'b0010; reset = 1'b1;
        cyc; reset = 1'b0; req_valid = '0; #1;
        chk("t5_rsp_a", 64'(rsp_valid), 64'h0);
        chk("t5_busy_a", 64'(busy), 64'h0);
        cyc; #1;
        chk("t5_rsp_b", 64'(rsp_valid), 64'h0);
        chk("t5_busy_b", 64'(busy), 64'h0);
        req_valid = 4'b1111; #1;
        chk("t5_ptr0", 64'(req_ready), 64'h1);
        cyc; req_valid = '0;
        cyc; #1;
        chk("t5_rsp", 64'(rsp_valid), 64'h1);
        chk("t5_data", 64'(rsp_data), 64'(lutf(10'h155)));
        cyc;
        // ptr = 1

        // idle with nonzero addresses present
        for (int i = 0; i < NREQ; i++) seta(i, ASZ'(10'h3F0 + i));
        req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t6_ready", 64'(req_ready), 64'h0);
            chk("t6_lut_a", 64'(lut_a), 64'h0);
            chk("t6_rsp", 64'(rsp_valid), 64'h0);
            chk("t6_busy", 64'(busy), 64'h0);
            cyc;
        end
        req_valid = 4'b1111; #1;
        chk("t6_ptr_kept", 64'(req_ready), 64'h2);
        cyc; req_valid = '0;
        cyc; cyc;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
